fetch_jmp_ctrl: RTL
===================

Name: fetch_jmp_ctrl

Overview:
- Sequences fetch redirection for branch/jump instructions in the MIPS pipeline.
- Decode's jump classification marks an instruction as a control-transfer with its target unresolved. This block tracks that pending jump until execute resolves it and the delay-slot instruction has left fetch.
- It then issues a single redirect to the fetch PC logic. It also stalls a second jump while one is pending, and keeps resolution statistics.

Parameters:
PC_W, 32, width of PC and redirect target
CNT_W, 16, width of statistic counters (wrap on overflow)
TIMEOUT, 64, max cycles in WAIT_RES before sticky error; 0 disables

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
id_fire  in  1  decode accepts an instruction this cycle
id_is_jmp  in  1  accepted instruction is a branch/jump (valid with id_fire)
slot_fire  in  1  delay-slot instruction leaves fetch into decode this cycle
ex_resolve_valid  in  1  execute resolves the pending jump this cycle
ex_taken  in  1  resolved jump is taken
ex_pc_dst  in  PC_W  resolved target (valid with ex_resolve_valid & ex_taken)
fetch_ready  in  1  fetch accepts the redirect this cycle
exc_flush  in  1  exception/eret flush; cancels everything
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  PC_W  redirect target
id_stall  out  1  decode must hold the current instruction
jmp_pending  out  1  state != IDLE
err_timeout  out  1  sticky: WAIT_RES exceeded TIMEOUT cycles
jmp_cnt  out  CNT_W  number of resolved jumps
taken_cnt  out  CNT_W  number of resolved taken jumps

Behaviour:
Reset:
- state=IDLE, slot_seen=0, target=0, timer=0.
- All outputs are 0.

State machine: IDLE, WAIT_RES, WAIT_SLOT, REDIRECT.
- IDLE: id_fire & id_is_jmp -> WAIT_RES; slot_seen<=0, timer<=0.
- WAIT_RES:
  - slot_fire sets slot_seen.
  - timer increments each cycle. When TIMEOUT!=0 and timer reaches TIMEOUT, err_timeout<=1 (sticky until reset); state is unchanged.
  - ex_resolve_valid & !ex_taken -> IDLE.
  - ex_resolve_valid & ex_taken: target<=ex_pc_dst. Go to REDIRECT if slot_seen | slot_fire, else WAIT_SLOT.
- WAIT_SLOT: slot_fire -> REDIRECT.
- REDIRECT:
  - redirect_valid=1, redirect_pc=target. Both are Moore outputs, i.e. a function of state only.
  - fetch_ready -> IDLE. Otherwise hold, with redirect_pc stable.

Counters:
- On every ex_resolve_valid accepted in WAIT_RES, jmp_cnt+=1. If ex_taken, taken_cnt+=1.
- Counters are not cleared by exc_flush.

Stall and ignored inputs:
- id_stall = (state!=IDLE) & id_fire & id_is_jmp, combinational.
- A stalled fire does not change state.
- ex_resolve_valid outside WAIT_RES is ignored and not counted.
- slot_fire outside WAIT_RES/WAIT_SLOT is ignored.

Latency:
- Resolve-taken at cycle t, with slot already seen -> redirect_valid high at t+1.
- slot_fire at cycle t in WAIT_SLOT -> redirect_valid at t+1.

Simultaneous events:
- id_fire & id_is_jmp in the same cycle as REDIRECT & fetch_ready: the new jump is stalled (state!=IDLE that cycle) and accepted next cycle.
- slot_fire and resolve in the same cycle in WAIT_RES: counts as slot seen.

exc_flush:
- Highest priority, in any state.
- Next state IDLE, slot_seen<=0, timer<=0. A resolve in that same cycle is not counted.
- redirect_valid drops the next cycle.
- err_timeout and the counters are kept.

Asynchronous reset mid-operation:
- Returns immediately to reset values; no redirect is emitted.

Target width: ex_pc_dst is stored unmodified (no alignment check).

Test Plan:
- Taken jump, slot before resolve: jmp at t0, slot_fire t1, resolve taken pc_dst=0xBFC00100 at t3, fetch_ready=1 -> redirect_valid only at t4 with 0xBFC00100; IDLE at t5; jmp_cnt=1, taken_cnt=1.
- Taken jump, resolve before slot: resolve taken 0x80001000 at t2, slot_fire at t5 -> WAIT_SLOT t3-t5, redirect_valid at t6; fetch_ready low t6-t8 holds redirect_pc=0x80001000 stable, IDLE after t9 accept.
- Not-taken: resolve ex_taken=0 -> no redirect_valid ever, IDLE next cycle, jmp_cnt=1, taken_cnt=0.
- Second jump while pending: id_fire&id_is_jmp in WAIT_RES -> id_stall=1 that cycle, state unchanged; same in REDIRECT with fetch_ready -> stalled, accepted next cycle (WAIT_RES).
- Flush: exc_flush in WAIT_SLOT and in REDIRECT -> IDLE next cycle, redirect_valid 0, later slot_fire/resolve ignored; flush coincident with resolve -> jmp_cnt unchanged.
- Timeout/reset: TIMEOUT=4, no resolve -> err_timeout=1 after 4 cycles in WAIT_RES and stays; resetn low mid-REDIRECT -> all outputs 0 immediately, counters 0.

Source files
------------

// File: rtl/fetch_jmp_ctrl.sv
// fetch_jmp_ctrl: tracks one unresolved branch/jump from decode until execute
// resolves it and its delay slot has left fetch, then issues one redirect
// to the fetch PC logic. A second jump is stalled in decode while one is
// pending. Keeps resolved and taken jump statistics.
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   id_fire, id_is_jmp      decode accepts an instruction / it is a jump
//   slot_fire               delay-slot instruction leaves fetch
//   ex_resolve_valid        execute resolves the pending jump
//   ex_taken, ex_pc_dst     resolution outcome and target
//   fetch_ready             fetch accepts the redirect
//   exc_flush               exception/eret flush, cancels the pending jump
//   redirect_valid/_pc      redirect request to fetch (Moore)
//   id_stall                decode must hold its jump
//   jmp_pending             a jump is being tracked
//   err_timeout             sticky: resolution took TIMEOUT cycles or more
//   jmp_cnt, taken_cnt      resolved / resolved-taken jump counters (wrap)
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | no jump tracked
// WAIT_RES  | jump accepted, waiting for execute to resolve it
// WAIT_SLOT | resolved taken, waiting for the delay slot to leave fetch
// REDIRECT  | redirect presented to fetch until fetch_ready
module fetch_jmp_ctrl #(
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_fire,
  input  logic             id_is_jmp,
  input  logic             slot_fire,
  input  logic             ex_resolve_valid,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_pc_dst,
  input  logic             fetch_ready,
  input  logic             exc_flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             id_stall,
  output logic             jmp_pending,
  output logic             err_timeout,
  output logic [CNT_W-1:0] jmp_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 2);
  localparam logic [TMR_W-1:0] TMR_LIM  = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RES,
    S_WAIT_SLOT,
    S_REDIRECT
  } state_e;

  state_e           state_q, state_d;
  logic             slot_seen_q, slot_seen_d;
  logic [PC_W-1:0]  target_q, target_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] jmp_cnt_q, jmp_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             jmp_req;

  assign jmp_req = id_fire & id_is_jmp;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      slot_seen_q <= 1'b0;
      target_q    <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      jmp_cnt_q   <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      slot_seen_q <= slot_seen_d;
      target_q    <= target_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      jmp_cnt_q   <= jmp_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_seen_d = slot_seen_q;
    target_d    = target_q;
    timer_d     = timer_q;
    err_d       = err_q;
    jmp_cnt_d   = jmp_cnt_q;
    taken_cnt_d = taken_cnt_q;

    if (exc_flush) begin
      // Flush beats everything, including a same-cycle resolve.
      state_d     = S_IDLE;
      slot_seen_d = 1'b0;
      timer_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (jmp_req) begin
            state_d     = S_WAIT_RES;
            slot_seen_d = 1'b0;
            timer_d     = '0;
          end
        end
        S_WAIT_RES: begin
          if (slot_fire) slot_seen_d = 1'b1;
          // Timer saturates so it cannot wrap back under the limit.
          if (timer_q != TMR_LIM) timer_d = timer_q + 1'b1;
          if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) err_d = 1'b1;
          if (ex_resolve_valid) begin
            jmp_cnt_d = jmp_cnt_q + 1'b1;
            if (ex_taken) begin
              taken_cnt_d = taken_cnt_q + 1'b1;
              target_d    = ex_pc_dst;
              state_d     = (slot_seen_q | slot_fire) ? S_REDIRECT : S_WAIT_SLOT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_WAIT_SLOT: begin
          if (slot_fire) state_d = S_REDIRECT;
        end
        S_REDIRECT: begin
          if (fetch_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign redirect_valid = (state_q == S_REDIRECT);
  assign redirect_pc    = (state_q == S_REDIRECT) ? target_q : '0;
  assign jmp_pending    = (state_q != S_IDLE);
  assign id_stall       = (state_q != S_IDLE) & jmp_req;
  assign err_timeout    = err_q;
  assign jmp_cnt        = jmp_cnt_q;
  assign taken_cnt      = taken_cnt_q;

endmodule
